// File: rtl/pld_intlv_if.sv
// pld_intlv_if: coded bit stream into the interleaver and interleaved bit stream out.
interface pld_intlv_if;
   logic       pld_di;
   logic       pld_di_vld;
   logic       pld_clr;
   logic       pld_do;
   logic       pld_do_vld;
   logic [3:0] pld_do_sym_num;
   modport master (output pld_di, pld_di_vld, pld_clr, input pld_do, pld_do_vld, pld_do_sym_num);
   modport slave (input pld_di, pld_di_vld, pld_clr, output pld_do, pld_do_vld, pld_do_sym_num);
endinterface

// File: rtl/pld_intlv.sv
// pld_intlv: 802.11a two-step block interleaver, ping-pong bit buffer written permuted, read in order.
module pld_intlv #(
   parameter int N_CBPS = 48,
   parameter int N_BPSC = 1
) (
   input logic        pld_clk,
   input logic        pld_rst,
   pld_intlv_if.slave bus
);
   localparam int AW = $clog2(N_CBPS);
   localparam int S = N_BPSC > 2 ? N_BPSC / 2 : 1;
   localparam logic [AW-1:0] LAST = AW'(N_CBPS - 1);
   function automatic int perm(int k);
      int i;
      i = (N_CBPS / 16) * (k % 16) + k / 16;
      return S * (i / S) + ((i + N_CBPS - (16 * i) / N_CBPS) % S);
   endfunction
   logic [AW-1:0]     lut [N_CBPS];
   logic [N_CBPS-1:0] mem [2];
   logic [AW-1:0]     wr_k, rd_ptr;
   logic [1:0]        full;
   logic              wr_bank, rd_bank, sym_inc;
   logic              wr_en, wr_last, rd_en, rd_last;
   // permutation table is built from constants only, so it folds to wiring
   genvar g;
   for (g = 0; g < N_CBPS; g++) begin : g_lut
      assign lut[g] = AW'(perm(g));
   end
   assign wr_en   = bus.pld_di_vld & ~bus.pld_clr;
   assign wr_last = wr_en & (wr_k == LAST);
   assign rd_en   = full[rd_bank];
   assign rd_last = rd_en & (rd_ptr == LAST);
   always_ff @(posedge pld_clk)
      if (wr_en) mem[wr_bank][lut[wr_k]] <= bus.pld_di;
   // writes and reads both alternate banks from 0, so the read bank is always the older full one
   always_ff @(posedge pld_clk or posedge pld_rst)
      if (pld_rst) begin
         wr_k               <= '0;
         wr_bank            <= 1'b0;
         full               <= '0;
         rd_bank            <= 1'b0;
         rd_ptr             <= '0;
         sym_inc            <= 1'b0;
         bus.pld_do         <= 1'b0;
         bus.pld_do_vld     <= 1'b0;
         bus.pld_do_sym_num <= '0;
      end else begin
         wr_k <= (bus.pld_clr | wr_last) ? '0 : wr_en ? wr_k + 1'b1 : wr_k;
         if (wr_last) wr_bank <= ~wr_bank;
         if (rd_last) full[rd_bank] <= 1'b0;
         if (wr_last) full[wr_bank] <= 1'b1;
         if (rd_en) bus.pld_do <= mem[rd_bank][rd_ptr];
         bus.pld_do_vld <= rd_en;
         rd_ptr <= rd_last ? '0 : rd_en ? rd_ptr + 1'b1 : rd_ptr;
         if (rd_last) rd_bank <= ~rd_bank;
         sym_inc <= rd_last;
         if (sym_inc) bus.pld_do_sym_num <= bus.pld_do_sym_num + 1'b1;
      end
endmodule

// File: doc/pld_intlv.md
PLD_INTLV -- requirements
Module: pld_intlv

Interface
REQ-001 SHALL have parameter N_CBPS, default 48, coded bits per OFDM symbol; legal values are 48, 96, 192 and 288.
REQ-002 SHALL have parameter N_BPSC, default 1, coded bits per subcarrier; legal values are 1, 2, 4 and 6, and N_CBPS = 48*N_BPSC.
REQ-003 SHALL have port pld_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port pld_rst, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-005 SHALL have port pld_di, input, 1 bit: coded payload bit from the convolutional encoder.
REQ-006 SHALL have port pld_di_vld, input, 1 bit: pld_di is valid this cycle; there is no backpressure.
REQ-007 SHALL have port pld_clr, input, 1 bit: synchronous clear that discards a partially written symbol.
REQ-008 SHALL have port pld_do, output, 1 bit: interleaved bit.
REQ-009 SHALL have port pld_do_vld, output, 1 bit: pld_do is valid this cycle.
REQ-010 SHALL have port pld_do_sym_num, output, 4 bits: index modulo 16 of the symbol currently being output.

Function
REQ-011 SHALL implement the two-step 802.11a block interleaver for input index k in 0..N_CBPS-1, with s = max(N_BPSC/2, 1):
- first permutation: i = (N_CBPS/16)*(k mod 16) + floor(k/16);
- second permutation: j = s*floor(i/s) + ((i + N_CBPS - floor(16*i/N_CBPS)) mod s);
- output position j carries input bit k.
REQ-012 SHALL compute the permutation with elaboration-time constants or a lookup table; it SHALL NOT use a runtime divider.
REQ-013 SHALL use a ping-pong buffer of two N_CBPS-bit banks, written at the permuted address j(k) and read at sequential addresses 0..N_CBPS-1.
REQ-014 SHALL keep a write counter wr_k (0..N_CBPS-1) that advances only on cycles with pld_di_vld=1, and SHALL hold wr_k while pld_di_vld=0, so gaps in input are tolerated mid-symbol.
REQ-015 SHALL, on the edge that captures input bit k = N_CBPS-1:
- wrap wr_k to 0;
- mark the written bank full;
- switch writes to the other bank.
REQ-016 SHALL register output bit 0 of a full bank on the rising edge after the edge that captured that symbol's last input bit (latency 1 cycle).
REQ-017 SHALL then output one bit per cycle with pld_do_vld=1 for exactly N_CBPS consecutive cycles.
REQ-018 SHALL, when the other bank is already full at the end of a read, start reading it on the next cycle with no idle gap, so pld_do_vld stays high across symbol boundaries.
REQ-019 SHALL drive pld_do_vld=0 and hold pld_do at its last value when no bank is being read.
REQ-020 SHALL sustain continuous input at 1 bit/clk without overflow, because a read of N_CBPS cycles never exceeds the fill time of the opposite bank.
REQ-021 SHALL increment pld_do_sym_num, wrapping 15 -> 0, on the cycle after the last output bit of each symbol.
REQ-022 SHALL, on pld_clr=1:
- reset wr_k to 0 and discard the partial bank;
- let a symbol already being read complete unaffected;
- give pld_clr priority over a simultaneous pld_di_vld, so that bit is dropped.

Reset
REQ-023 SHALL, while pld_rst=1, asynchronously set: pld_do=0, pld_do_vld=0, pld_do_sym_num=0, wr_k=0, both banks not-full, write bank = bank 0, read pointer = 0.
REQ-024 SHALL, on reset asserted mid-symbol or mid-read, discard all buffered data; pld_do_vld SHALL remain 0 until a new full symbol has been written.
REQ-025 SHALL NOT require the buffer contents themselves to be reset.

Verification
REQ-026 SHALL be verified with N_CBPS=48, N_BPSC=1: 48 valid bits with only k=1 set -> exactly one 1, at output position 3; with only k=16 set -> output position 1.
REQ-027 SHALL be verified with N_CBPS=192, N_BPSC=4: only k=1 set -> output position 13; an all-ones symbol -> 192 ones.
REQ-028 SHALL be verified with continuous pld_di_vld for 20 symbols of N_CBPS=48:
- pld_do_vld high for 960 consecutive cycles, starting 1 cycle after the last bit of symbol 0;
- pld_do_sym_num sequencing 0..15,0..3;
- output matching the reference-model permutation.
REQ-029 SHALL be verified with pld_di_vld toggling 1/0 every cycle -> identical output bit order to the continuous case, with a gap of N_CBPS cycles between output symbols.
REQ-030 SHALL be verified with pld_clr pulsed after 20 bits of a symbol, followed by 48 fresh bits -> only the fresh symbol is output, and pld_do_sym_num increments by 1.
REQ-031 SHALL be verified with pld_rst asserted during output bit 10 -> pld_do_vld=0 immediately, pld_do_sym_num=0, and no output until the next full symbol.
